// File: rtl/fetch_sequencer.sv
// Purpose : decodes the fetched instruction stream and drives fetch redirect and hold controls.
// Latency : every output is registered, so the response to ins in cycle n appears in cycle n+1.
// Backpr. : no handshake; fetch is held with stall/stall_pm for MUL and HLT.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   ins, ins_addr           instruction from fetch and its address
//   zero_flag               ALU zero flag, aligned with ins
//   jmp_loc, pc_mux_sel     redirect target and select toward fetch
//   stall, stall_pm         hold fetch address / fetched instruction
//   ins_out, ins_valid      instruction to decode (zero when not valid)
//   halted                  HLT has retired; cleared only by reset
//   ras_err                 sticky return-address-stack overflow/underflow
module fetch_sequencer #(
  parameter int RAS_DEPTH  = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [15:0] ins_addr,
  input  logic        zero_flag,
  output logic [15:0] jmp_loc,
  output logic        pc_mux_sel,
  output logic        stall,
  output logic        stall_pm,
  output logic [31:0] ins_out,
  output logic        ins_valid,
  output logic        halted,
  output logic        ras_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [PTR_W:0]   SP_FULL  = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_BZ   = 5'b10001;
  localparam logic [4:0] OP_BNZ  = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_MUL  = 5'b10101;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_MULWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // wr_ptr points at the next free slot; sp counts live entries (0..RAS_DEPTH)
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   sp_q, sp_d;
  logic [15:0]      ras_q [RAS_DEPTH];
  logic [15:0]      ras_d [RAS_DEPTH];
  logic             ras_err_q, ras_err_d;

  logic [15:0] jmp_loc_q, jmp_loc_d;
  logic        pc_mux_sel_q, pc_mux_sel_d;
  logic        stall_q, stall_d;
  logic        stall_pm_q, stall_pm_d;
  logic [31:0] ins_out_q, ins_out_d;
  logic        ins_valid_q, ins_valid_d;
  logic        halted_q, halted_d;

  logic [4:0]       opcode;
  logic [15:0]      target;
  logic [PTR_W-1:0] rd_ptr;

  assign opcode = ins[31:27];
  assign target = ins[15:0];
  assign rd_ptr = wr_ptr_q - PTR_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    sp_d         = sp_q;
    ras_d        = ras_q;
    ras_err_d    = ras_err_q;
    jmp_loc_d    = 16'h0000;
    pc_mux_sel_d = 1'b0;
    stall_d      = 1'b0;
    stall_pm_d   = 1'b0;
    ins_out_d    = 32'h0;
    ins_valid_d  = 1'b0;
    halted_d     = 1'b0;

    case (state_q)
      S_RUN: begin
        // control-flow instructions are still forwarded to decode
        ins_out_d   = ins;
        ins_valid_d = 1'b1;
        case (opcode)
          OP_JMP: begin
            jmp_loc_d    = target;
            pc_mux_sel_d = 1'b1;
            state_d      = S_FLUSH;
          end
          OP_BZ, OP_BNZ: begin
            if (zero_flag == (opcode == OP_BZ)) begin
              jmp_loc_d    = target;
              pc_mux_sel_d = 1'b1;
              state_d      = S_FLUSH;
            end
          end
          OP_CALL: begin
            // full stack wraps: the oldest entry is overwritten
            ras_d[wr_ptr_q] = ins_addr + 16'd1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            if (sp_q == SP_FULL) ras_err_d = 1'b1;
            else                 sp_d      = sp_q + (PTR_W+1)'(1);
            jmp_loc_d    = target;
            pc_mux_sel_d = 1'b1;
            state_d      = S_FLUSH;
          end
          OP_RET: begin
            // empty stack still redirects, to address 0
            if (sp_q == '0) begin
              ras_err_d = 1'b1;
            end else begin
              jmp_loc_d = ras_q[rd_ptr];
              wr_ptr_d  = rd_ptr;
              sp_d      = sp_q - (PTR_W+1)'(1);
            end
            pc_mux_sel_d = 1'b1;
            state_d      = S_FLUSH;
          end
          OP_MUL: begin
            cnt_d   = CNT_INIT;
            state_d = S_MULWAIT;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_FLUSH: state_d = S_RUN;  // wrong-path instruction dropped
      S_MULWAIT: begin
        stall_d    = 1'b1;
        stall_pm_d = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RUN;
      end
      S_HALT: begin
        stall_d    = 1'b1;
        stall_pm_d = 1'b1;
        halted_d   = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      sp_q         <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 16'h0000;
      ras_err_q    <= 1'b0;
      jmp_loc_q    <= 16'h0000;
      pc_mux_sel_q <= 1'b0;
      stall_q      <= 1'b0;
      stall_pm_q   <= 1'b0;
      ins_out_q    <= 32'h0;
      ins_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      sp_q         <= sp_d;
      ras_q        <= ras_d;
      ras_err_q    <= ras_err_d;
      jmp_loc_q    <= jmp_loc_d;
      pc_mux_sel_q <= pc_mux_sel_d;
      stall_q      <= stall_d;
      stall_pm_q   <= stall_pm_d;
      ins_out_q    <= ins_out_d;
      ins_valid_q  <= ins_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign jmp_loc    = jmp_loc_q;
  assign pc_mux_sel = pc_mux_sel_q;
  assign stall      = stall_q;
  assign stall_pm   = stall_pm_q;
  assign ins_out    = ins_out_q;
  assign ins_valid  = ins_valid_q;
  assign halted     = halted_q;
  assign ras_err    = ras_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : scoreboard bench for fetch_sequencer against a schedule-based reference model.
// Latency : expected outputs are due one clock after the inputs that cause them.
// Backpr. : none; every cycle produces one expected record.
module tb_fetch_sequencer;

  localparam int RAS_DEPTH  = 4;
  localparam int MUL_CYCLES = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = 32'h0;
  logic [15:0] ins_addr = 16'h0;
  logic        zero_flag = 1'b0;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel, stall, stall_pm, ins_valid, halted, ras_err;
  logic [31:0] ins_out;

  fetch_sequencer #(.RAS_DEPTH(RAS_DEPTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_addr(ins_addr), .zero_flag(zero_flag),
    .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .stall(stall), .stall_pm(stall_pm),
    .ins_out(ins_out), .ins_valid(ins_valid), .halted(halted), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          due;
    logic [31:0] ins_out;
    logic        vld, pc, chk_jl, stall, halted, err;
    logic [15:0] jl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: tracks the first cycle whose input will be accepted,
  // whether the skipped cycles are MUL holds, halt status and the RAS contents.
  int          acc_from = 0;
  bit          skip_is_stall = 0;
  bit          m_halt = 0;
  bit          m_err = 0;
  logic [15:0] m_ras[$];

  task automatic model(input bit rst, input logic [31:0] i, input logic [15:0] a,
                       input bit z, input int t);
    exp_t e;
    logic [4:0]  op;
    logic [15:0] tg;
    e = '{due: t + 1, ins_out: 32'h0, vld: 0, pc: 0, chk_jl: 0,
          stall: 0, halted: 0, err: 0, jl: 16'h0};
    op = i[31:27];
    tg = i[15:0];
    if (rst) begin
      m_ras.delete();
      m_err = 0;
      m_halt = 0;
      acc_from = t + 1;
      e.chk_jl = 1;
    end else if (m_halt) begin
      e.stall = 1;
      e.halted = 1;
    end else if (t < acc_from) begin
      e.stall = skip_is_stall;
    end else begin
      e.vld = 1;
      e.ins_out = i;
      if (op == 5'b10011) begin
        if (m_ras.size() == RAS_DEPTH) begin
          m_ras.delete(0);
          m_err = 1;
        end
        m_ras.push_back(a + 16'd1);
      end
      if (op == 5'b10100) begin
        if (m_ras.size() == 0) begin
          tg = 16'h0000;
          m_err = 1;
        end else begin
          tg = m_ras.pop_back();
        end
      end
      if (op == 5'b10000 || op == 5'b10011 || op == 5'b10100 ||
          (op == 5'b10001 && z) || (op == 5'b10010 && !z)) begin
        e.pc = 1;
        e.chk_jl = 1;
        e.jl = tg;
        acc_from = t + 2;
        skip_is_stall = 0;
      end
      if (op == 5'b10101) begin
        acc_from = t + MUL_CYCLES;
        skip_is_stall = 1;
      end
      if (op == 5'b11111) m_halt = 1;
    end
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit rst, input logic [31:0] i, input logic [15:0] a, input bit z);
    @(posedge clk);
    #1;
    reset = rst;
    ins = i;
    ins_addr = a;
    zero_flag = z;
    model(rst, i, a, z, edge_cnt);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [15:0] tg);
    return {op, 11'($urandom), tg};
  endfunction

  function automatic logic [31:0] filler();
    return mk(5'($urandom_range(0, 15)), 16'($urandom));
  endfunction

  // Monitor: compare every record whose due cycle has been reached.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
        e = sb.pop_front();
        ok = (ins_out === e.ins_out) && (ins_valid === e.vld) && (pc_mux_sel === e.pc) &&
             (stall === e.stall) && (stall_pm === e.stall) && (halted === e.halted) &&
             (ras_err === e.err) && (!e.chk_jl || jmp_loc === e.jl);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL cyc%0d got ins=%h v=%b pc=%b jl=%h st=%b stpm=%b h=%b err=%b exp ins=%h v=%b pc=%b jl=%h st=%b h=%b err=%b",
                   e.due, ins_out, ins_valid, pc_mux_sel, jmp_loc, stall, stall_pm, halted, ras_err,
                   e.ins_out, e.vld, e.pc, e.jl, e.stall, e.halted, e.err);
        end
      end
    end
  end

  initial begin
    logic [15:0] pc;
    int r;
    // reset held two cycles with a JMP on ins, then a plain instruction
    cyc(1, mk(5'b10000, 16'h0040), 16'h0000, 0);
    cyc(1, mk(5'b10000, 16'h0040), 16'h0000, 0);
    cyc(0, {5'b00000, 27'h0001234}, 16'h0000, 0);
    cyc(0, filler(), 16'h0001, 0);
    // JMP, flushed slot, target instruction
    cyc(0, mk(5'b10000, 16'h0040), 16'h0010, 0);
    cyc(0, filler(), 16'h0011, 0);
    cyc(0, filler(), 16'h0040, 0);
    // BZ not taken then taken
    cyc(0, mk(5'b10001, 16'h0080), 16'h0041, 0);
    cyc(0, filler(), 16'h0042, 0);
    cyc(0, mk(5'b10001, 16'h0080), 16'h0043, 1);
    cyc(0, filler(), 16'h0044, 1);
    cyc(0, filler(), 16'h0080, 0);
    // CALL then RET
    cyc(0, mk(5'b10011, 16'h0100), 16'h0020, 0);
    cyc(0, filler(), 16'h0021, 0);
    cyc(0, mk(5'b10100, 16'h0000), 16'h0100, 0);
    cyc(0, filler(), 16'h0101, 0);
    cyc(0, filler(), 16'h0021, 0);
    // five nested CALLs (one from 16'hFFFF), then five RETs
    for (int k = 0; k < 5; k++) begin
      cyc(0, mk(5'b10011, 16'h0200 + 16'(k)), (k == 4) ? 16'hFFFF : 16'h0300 + 16'(k), 0);
      cyc(0, filler(), 16'h0400, 0);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, mk(5'b10100, 16'(k)), 16'h0500, 0);
      cyc(0, filler(), 16'h0501, 0);
    end
    // MUL after a fresh reset
    cyc(1, filler(), 16'h0000, 0);
    cyc(0, mk(5'b10101, 16'h0000), 16'h0000, 0);
    for (int k = 0; k < 5; k++) cyc(0, filler(), 16'h0001 + 16'(k), 0);
    // HLT held for 20 cycles, then reset pulse
    cyc(0, mk(5'b11111, 16'h0000), 16'h0010, 0);
    for (int k = 0; k < 20; k++) cyc(0, filler(), 16'h0011, 0);
    cyc(1, filler(), 16'h0000, 0);
    cyc(0, filler(), 16'h0000, 0);
    cyc(0, filler(), 16'h0001, 0);
    // randomized traffic
    pc = 16'h0;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      pc = ($urandom_range(0, 9) == 0) ? 16'hFFFF : pc + 16'd1;
      if (r < 3) cyc(1, filler(), pc, $urandom_range(0, 1) == 1);
      else if (r < 40) cyc(0, filler(), pc, $urandom_range(0, 1) == 1);
      else if (r < 48) cyc(0, mk(5'b10000, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else if (r < 56) cyc(0, mk(5'b10001, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else if (r < 64) cyc(0, mk(5'b10010, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else if (r < 75) cyc(0, mk(5'b10011, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else if (r < 87) cyc(0, mk(5'b10100, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else if (r < 96) cyc(0, mk(5'b10101, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else if (r < 97) cyc(0, mk(5'b11111, 16'($urandom)), pc, $urandom_range(0, 1) == 1);
      else cyc(0, filler(), pc, 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending records exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
